// File: rtl/serial_sub32.sv
// serial_sub32: 32-bit subtractor computing a - b - bi one nibble per clock, LSB first.
// Reports borrow-out and signed overflow, and pulses done when the result is valid.
module serial_sub32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bi,
  output logic [31:0] d,
  output logic        bo,
  output logic        v,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [31:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic        bo_q, bo_d, v_q, v_d;
  logic [3:0]  a_nib, b_nib;
  logic [4:0]  sum;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      v_q     <= v_d;
    end
  // Subtraction as a + ~b + carry, where the carry chain starts at ~bi.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    bo_d    = bo_q;
    v_d     = v_q;
    a_nib   = 4'(a_q >> {cnt_q, 2'b00});
    b_nib   = 4'(b_q >> {cnt_q, 2'b00});
    sum     = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'd0, carry_q};
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        cnt_d   = '0;
        carry_d = ~bi;
        state_d = CALC;
      end
      CALC: begin
        d_d[{cnt_q, 2'b00} +: 4] = sum[3:0];
        carry_d = sum[4];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          bo_d    = ~sum[4];
          v_d     = (a_q[31] ^ b_q[31]) & (sum[3] ^ a_q[31]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign d    = d_q;
  assign bo   = bo_q;
  assign v    = v_q;
  assign busy = state_q == CALC;
  assign done = state_q == DONE;
endmodule

// File: doc/serial_sub32.md
SERIAL_SUB32 -- requirements
Module: serial_sub32

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), clock and reset first:
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 a  input  32  minuend; captured when start is accepted.
REQ-006 b  input  32  subtrahend; captured when start is accepted.
REQ-007 bi  input  1  borrow-in; captured when start is accepted.
REQ-008 d  output  32  difference a - b - bi, registered.
REQ-009 bo  output  1  borrow-out (1 when a < b + bi, unsigned), registered.
REQ-010 v  output  1  signed overflow of a - b - bi, registered.
REQ-011 busy  output  1  high while an operation is in progress (CALC state).
REQ-012 done  output  1  one-cycle pulse when d, bo and v become valid.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 IDLE: if start=1 at a clk edge, the block SHALL capture a, b and bi into internal registers, clear the nibble counter to 0, set the internal carry to ~bi, and enter CALC.
REQ-015 CALC: each clk edge SHALL process one 4-bit nibble i (i = counter, LSB nibble first) as {c, s} = a_nib + ~b_nib + carry, write s to d[4i+3:4i], store c as carry, and increment the counter.
REQ-016 CALC SHALL last exactly 8 edges; on the edge processing nibble 7 the block SHALL enter DONE and update bo = ~c and v = (a[31] != b[31]) & (d[31] != a[31]), using the final d[31].
REQ-017 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE on the next edge.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+8 and low after edge k+9.
REQ-019 busy SHALL be 1 only in CALC; done SHALL be 1 only in DONE.
REQ-020 start SHALL be ignored in CALC and DONE; a and b changing during an operation SHALL NOT affect the result.
REQ-021 d, bo and v SHALL hold their last values in IDLE until the next operation writes them. d bits not yet processed in CALC MAY hold stale data and SHALL NOT be relied upon before done.
REQ-022 Arithmetic SHALL be modulo 2^32; the results SHALL equal the combinational result of a + ~b + ~bi with borrow = ~carry-out.
REQ-023 Back-to-back operations: start held high continuously SHALL launch a new operation on the first edge in IDLE after DONE, giving a 10-cycle issue interval.

Reset
REQ-024 When reset_n=0, regardless of clk, the block SHALL force state=IDLE, counter=0, carry=0, d=0, bo=0, v=0, busy=0 and done=0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.

Verification
REQ-026 a=0, b=0, bi=0, start pulse -> 9 edges later d=32'h00000000, bo=0, v=0, single-cycle done.
REQ-027 a=0, b=1, bi=0 -> d=32'hFFFFFFFF, bo=1, v=0.
REQ-028 a=32'h80000000, b=1, bi=0 -> d=32'h7FFFFFFF, bo=0, v=1. Also a=5, b=3, bi=1 -> d=1, bo=0, v=0.
REQ-029 Start pulsed again with a=32'hFFFFFFFF during CALC of a=32'h12345678, b=32'h02345678 -> ignored; d=32'h10000000, busy high for exactly 8 cycles.
REQ-030 reset_n low for 1 cycle at the 4th CALC cycle -> all outputs 0 immediately, no done pulse. A following start with a=32'hA, b=32'hE, bi=1 -> d=32'hFFFFFFFB, bo=1.
REQ-031 A bench SHALL compare every result against a reference model {bo, d} = {1'b0, a} - b - bi over at least 1000 random operands, including all-ones and all-zeros operands.
